// File: rtl/dht_report_pkg.sv
// Shared types, ASCII constants and BCD helpers for the DHT11 UART reporter.
package dht_report_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CONVERT = 3'd1,
    LOAD    = 3'd2,
    SEND    = 3'd3,
    FINISH  = 3'd4
  } state_t;

  localparam logic [7:0] CH_T    = 8'h54;
  localparam logic [7:0] CH_H    = 8'h48;
  localparam logic [7:0] CH_EQ   = 8'h3D;
  localparam logic [7:0] CH_SP   = 8'h20;
  localparam logic [7:0] CH_CR   = 8'h0D;
  localparam logic [7:0] CH_LF   = 8'h0A;
  localparam logic [7:0] CH_E    = 8'h45;
  localparam logic [7:0] CH_R    = 8'h52;
  localparam logic [7:0] CH_ZERO = 8'h30;

  localparam int MSG_LEN_OK  = 13;
  localparam int MSG_LEN_ERR = 5;

  // One double-dabble iteration on {hundreds, tens, units, binary[7:0]}.
  function automatic logic [19:0] dd_step(input logic [19:0] x);
    logic [19:0] y;
    y = x;
    if (y[11:8]  >= 4'd5) y[11:8]  = y[11:8]  + 4'd3;
    if (y[15:12] >= 4'd5) y[15:12] = y[15:12] + 4'd3;
    if (y[19:16] >= 4'd5) y[19:16] = y[19:16] + 4'd3;
    return {y[18:0], 1'b0};
  endfunction

  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return CH_ZERO + {4'd0, d};
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter, LSB first; every bit lasts exactly BAUD_DIV clocks.
module uart_tx_byte #(
  parameter int BAUD_DIV = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       tx_done,
  output logic       tx_busy
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_idx;
  logic [8:0]    shreg;
  logic          tx_q;
  logic          busy_q;
  logic          done_q;

  // Handshake: data is taken on any clock where start=1 and tx_busy=0; start is
  // ignored while tx_busy=1; tx_done pulses for one clock right after the stop bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '1;
    end else begin
      done_q <= 1'b0;
      if (!busy_q) begin
        if (start) begin
          busy_q   <= 1'b1;
          tx_q     <= 1'b0;
          shreg    <= {1'b1, data};
          baud_cnt <= '0;
          bit_idx  <= '0;
        end
      end else if (baud_cnt == CW'(BAUD_DIV - 1)) begin
        baud_cnt <= '0;
        if (bit_idx == 4'd9) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end else begin
          tx_q    <= shreg[0];
          shreg   <= {1'b1, shreg[8:1]};
          bit_idx <= bit_idx + 4'd1;
        end
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end

  assign tx      = tx_q;
  assign tx_done = done_q;
  assign tx_busy = busy_q;

endmodule

// File: rtl/dht_uart_reporter.sv
// Captures a DHT11 result word and prints "T=ddd H=ddd\r\n" (or "ERR\r\n") over UART.
module dht_uart_reporter
  import dht_report_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115200,
  parameter int BAUD_DIV = CLK_FREQ / BAUD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] data_in,
  input  logic        data_valid,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  state_t      state, state_n;
  logic        dv_q;
  logic        trig;
  logic        err_q;
  logic [19:0] bcd_t, bcd_h;
  logic [2:0]  cnv_cnt;
  logic [3:0]  idx;
  logic [3:0]  last_idx;
  logic        tx_start;
  logic        tx_done;
  logic        tx_busy;
  logic [7:0]  ch;
  state_t      first_state;

  // FINISH already has busy low, so an edge arriving there is accepted too.
  assign trig        = data_valid & ~dv_q & ((state == IDLE) | (state == FINISH));
  assign first_state = (data_in == 16'h0000) ? LOAD : CONVERT;
  assign last_idx    = err_q ? 4'(MSG_LEN_ERR - 1) : 4'(MSG_LEN_OK - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n  = state;
    tx_start = 1'b0;
    case (state)
      IDLE:    if (trig) state_n = first_state;
      CONVERT: if (cnv_cnt == 3'd7) state_n = LOAD;
      LOAD: begin
        tx_start = 1'b1;
        state_n  = SEND;
      end
      SEND:    if (tx_done) state_n = (idx == last_idx) ? FINISH : LOAD;
      FINISH:  state_n = trig ? first_state : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // The BCD shift registers double as the capture register for both bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dv_q    <= 1'b0;
      err_q   <= 1'b0;
      bcd_t   <= '0;
      bcd_h   <= '0;
      cnv_cnt <= '0;
      idx     <= '0;
    end else begin
      dv_q <= data_valid;
      if (trig) begin
        bcd_t   <= {12'd0, data_in[15:8]};
        bcd_h   <= {12'd0, data_in[7:0]};
        err_q   <= (data_in == 16'h0000);
        cnv_cnt <= '0;
        idx     <= '0;
      end else if (state == CONVERT) begin
        bcd_t   <= dd_step(bcd_t);
        bcd_h   <= dd_step(bcd_h);
        cnv_cnt <= cnv_cnt + 3'd1;
      end else if (state == SEND && tx_done) begin
        idx <= idx + 4'd1;
      end
    end
  end

  always_comb begin
    ch = CH_SP;
    if (err_q) begin
      case (idx)
        4'd0:       ch = CH_E;
        4'd1, 4'd2: ch = CH_R;
        4'd3:       ch = CH_CR;
        4'd4:       ch = CH_LF;
        default:    ch = CH_SP;
      endcase
    end else begin
      case (idx)
        4'd0:       ch = CH_T;
        4'd1, 4'd7: ch = CH_EQ;
        4'd2:       ch = digit_char(bcd_t[19:16]);
        4'd3:       ch = digit_char(bcd_t[15:12]);
        4'd4:       ch = digit_char(bcd_t[11:8]);
        4'd5:       ch = CH_SP;
        4'd6:       ch = CH_H;
        4'd8:       ch = digit_char(bcd_h[19:16]);
        4'd9:       ch = digit_char(bcd_h[15:12]);
        4'd10:      ch = digit_char(bcd_h[11:8]);
        4'd11:      ch = CH_CR;
        4'd12:      ch = CH_LF;
        default:    ch = CH_SP;
      endcase
    end
  end

  // The transmitter is always idle in LOAD, so every start is taken; the
  // SEND->LOAD->start path leaves a fixed two-clock high gap between characters.
  uart_tx_byte #(.BAUD_DIV(BAUD_DIV)) u_tx (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (tx_start),
    .data    (ch),
    .tx      (tx),
    .tx_done (tx_done),
    .tx_busy (tx_busy)
  );

  assign busy = (state == CONVERT) | (state == LOAD) | (state == SEND);
  assign done = (state == FINISH);

endmodule

// File: tb/tb_dht_uart_reporter.sv
// Self-checking bench: decodes tx frames and compares against a text-level message model.
module tb_dht_uart_reporter;

  localparam int BD    = 16;
  localparam int FRAME = 10 * BD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] data_in = 16'h0;
  logic        data_valid = 1'b0;
  logic        tx, busy, done;

  dht_uart_reporter #(.CLK_FREQ(1_600_000), .BAUD(100_000), .BAUD_DIV(BD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .data_valid (data_valid),
    .tx         (tx),
    .busy       (busy),
    .done       (done)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int          tot = 0;
  int          bad = 0;
  logic [7:0]  exp_q[$];
  int          frames_rx = 0;
  int          done_cnt = 0;
  int          busy_cyc = 0;
  int          msg_frame = 0;
  int unsigned cap_cyc = 0;
  int unsigned last_end_cyc = 0;
  int          first_gap = -1;
  logic        bit_check_en = 1'b0;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (busy) busy_cyc++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tot++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Reference model: the text line a result word should produce.
  function automatic void model_line(input logic [15:0] w);
    int t, h;
    if (w == 16'h0000) begin
      exp_q.push_back(8'h45); exp_q.push_back(8'h52); exp_q.push_back(8'h52);
      exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    end else begin
      t = int'(w[15:8]);
      h = int'(w[7:0]);
      exp_q.push_back(8'h54); exp_q.push_back(8'h3D);
      exp_q.push_back(8'(48 + t / 100)); exp_q.push_back(8'(48 + (t / 10) % 10)); exp_q.push_back(8'(48 + t % 10));
      exp_q.push_back(8'h20); exp_q.push_back(8'h48); exp_q.push_back(8'h3D);
      exp_q.push_back(8'(48 + h / 100)); exp_q.push_back(8'(48 + (h / 10) % 10)); exp_q.push_back(8'(48 + h % 10));
      exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    end
  endfunction

  // ---------------- UART monitor ----------------
  initial begin
    logic        smp [FRAME];
    logic [7:0]  b;
    logic        shape_ok;
    logic        aborted;
    logic [9:0]  pat;
    int unsigned st;
    int          gap;
    forever begin
      @(negedge clk);
      if (rst_n && tx === 1'b0) begin
        st = cyc;
        smp[0] = 1'b0;
        aborted = 1'b0;
        for (int i = 1; i < FRAME; i++) begin
          @(negedge clk);
          if (!rst_n) begin
            aborted = 1'b1;
            break;
          end
          smp[i] = tx;
        end
        if (!aborted) begin
          shape_ok = 1'b1;
          for (int k = 0; k < 10; k++)
            for (int j = 0; j < BD; j++)
              if (smp[k*BD+j] !== smp[k*BD]) shape_ok = 1'b0;
          for (int k = 0; k < 8; k++) b[k] = smp[(k+1)*BD + BD/2];
          check("frame_shape", {31'd0, shape_ok}, 1);
          check("stop_bit", {31'd0, smp[9*BD + BD/2]}, 1);
          if (msg_frame == 0) begin
            check("start_latency", {31'd0, (st - cap_cyc) <= 12}, 1);
          end else begin
            gap = int'(st - last_end_cyc) - 1;
            check("char_gap_max", {31'd0, gap <= 2}, 1);
            if (first_gap < 0) first_gap = gap;
            else check("char_gap_const", gap, first_gap);
          end
          last_end_cyc = cyc;
          if (bit_check_en) begin
            pat = {1'b1, 8'h54, 1'b0};
            for (int k = 0; k < 10; k++) begin
              check("t_bit_head", {31'd0, smp[k*BD]}, {31'd0, pat[k]});
              check("t_bit_tail", {31'd0, smp[k*BD + BD - 1]}, {31'd0, pat[k]});
            end
            bit_check_en = 1'b0;
          end
          if (exp_q.size() == 0) check("extra_char", {24'd0, b}, 32'h100);
          else                   check("char", {24'd0, b}, {24'd0, exp_q.pop_front()});
          frames_rx++;
          msg_frame++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic trigger(input logic [15:0] w, input int hold, input bit accept);
    @(posedge clk); #1;
    data_in = w;
    data_valid = 1'b1;
    if (accept) begin
      msg_frame = 0;
      busy_cyc = 0;
    end
    @(posedge clk); #1;
    if (accept) cap_cyc = cyc;
    repeat (hold - 1) begin
      @(posedge clk); #1;
    end
    data_valid = 1'b0;
    data_in = 16'($urandom);
  endtask

  task automatic wait_done(input int limit);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", {31'd0, seen}, 1);
    repeat (4) @(negedge clk);
  endtask

  task automatic finish_msg(input int dc0);
    wait_done(FRAME * 15);
    check("exp_drained", exp_q.size(), 0);
    check("done_once", done_cnt - dc0, 1);
    check("busy_low", {31'd0, busy}, 0);
    check("busy_time", {31'd0, busy_cyc <= 130 * BD + 40}, 1);
  endtask

  task automatic run_msg(input logic [15:0] w, input int hold);
    int dc0;
    dc0 = done_cnt;
    model_line(w);
    trigger(w, hold, 1'b1);
    finish_msg(dc0);
  endtask

  task automatic quiet_check(input string tag, input int n);
    int lows, busies;
    lows = 0;
    busies = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
      if (busy !== 1'b0) busies++;
    end
    check(tag, lows + busies, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int dc0, f0;
    logic seen;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", {31'd0, tx}, 1);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // Normal line with exact bit timing on the first 'T'.
    bit_check_en = 1'b1;
    run_msg(16'h1928, 1);

    // Level held high: exactly one message.
    run_msg(16'hFFFF, 1000);
    quiet_check("no_retrigger", 300);

    // Error word.
    f0 = frames_rx;
    run_msg(16'h0000, 1);
    check("err_frames", frames_rx - f0, 5);

    // Second trigger while busy is dropped.
    dc0 = done_cnt;
    model_line(16'h0A05);
    trigger(16'h0A05, 1, 1'b1);
    repeat (3 * FRAME) @(posedge clk);
    trigger(16'h1111, 1, 1'b0);
    finish_msg(dc0);
    quiet_check("no_queued_msg", 200);
    run_msg(16'h1111, 1);

    // Reset during the 4th character.
    model_line(16'h1928);
    f0 = frames_rx;
    trigger(16'h1928, 1, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < FRAME * 6; i++) begin
      @(negedge clk);
      if (frames_rx - f0 >= 3) begin
        seen = 1'b1;
        break;
      end
    end
    check("reach_4th_char", {31'd0, seen}, 1);
    repeat (4 * BD) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort_tx", {31'd0, tx}, 1);
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_done", {31'd0, done}, 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    quiet_check("idle_after_reset", 300);
    run_msg(16'h1928, 1);

    // Randomised words and trigger widths.
    for (int n = 0; n < 8; n++) begin
      run_msg(16'($urandom_range(0, 16'hFFFF)), $urandom_range(1, 6));
      repeat ($urandom_range(1, 20)) @(posedge clk);
    end

    check("final_queue", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule

// File: doc/dht_uart_reporter.md
Name: dht_uart_reporter

Overview:
- Downstream consumer of the DHT11 sensor reader.
- Captures the 16-bit result word {temperature[15:8], humidity[7:0]} when the reader raises ready.
- Converts both bytes to 3-digit decimal ASCII and serialises the line "T=ddd H=ddd\r\n" on a UART TX pin (8N1, LSB first).
- A result word of 0x0000, which the reader uses for error or bad checksum, is reported as "ERR\r\n".

Parameters:
- CLK_FREQ, 100000000: system clock frequency in Hz.
- BAUD, 115200: serial bit rate.
- BAUD_DIV, CLK_FREQ/BAUD (868, integer truncation): clocks per serial bit.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous active-low reset.
- data_in  in  16  {temperature, humidity} from the sensor reader.
- data_valid  in  1  reader ready flag; may be a pulse or a level.
- tx  out  1  UART serial output; idles high.
- busy  out  1  high while a message is being converted or sent.
- done  out  1  one-clock pulse when the last stop bit of a message completes.

Behaviour:
- Interface: one clock (clk). Reset rst_n is asynchronous and active-low.
- Reset values: tx=1, busy=0, done=0. The FSM goes to IDLE and the capture register clears.
- Reset mid-message aborts immediately: tx returns high asynchronously and no partial character is resumed.
- Trigger: a rising edge of data_valid. The block keeps a registered copy of data_valid and detects the edge with it, so a level held high triggers exactly once.
- Capture:
  - data_in is latched on the same clk edge that sees the edge.
  - busy rises on that edge.
  - An edge seen while busy=1 is ignored: no queueing, and the message in flight is unaffected.
- FSM states:
  - IDLE: wait for a trigger, then go to CONVERT. If the captured word is 0x0000, go straight to LOAD in ERR mode.
  - CONVERT: double-dabble binary-to-BCD on both bytes in parallel. Lasts exactly 8 clocks. Produces hundreds/tens/units, each digit 0-9, hundreds ≤ 2.
  - LOAD: select the next character by index and hand it to the byte transmitter.
  - SEND: wait for the transmitter to finish. Then increment the index and go to LOAD, or go to FINISH after the last character.
  - FINISH: assert done for 1 clock, drop busy in the same clock, return to IDLE.
- Character sequence, normal mode (13 chars, index 0-12):
  - 'T'(0x54), '='(0x3D), Th, Tt, Tu, ' '(0x20), 'H'(0x48), '='(0x3D), Hh, Ht, Hu, CR(0x0D), LF(0x0A).
  - Each digit is sent as 0x30 + value; leading zeros are kept.
- Character sequence, ERR mode (5 chars): 'E','R','R',CR,LF.
- Timing:
  - Frame per character: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
  - Every bit is exactly BAUD_DIV clocks.
  - The first start bit begins ≤ 12 clocks after the capturing edge.
  - Between characters, tx stays high for 0-2 clocks. Implementation chooses the gap, but it must be constant.
  - Total busy time, normal mode: 13×10×BAUD_DIV + overhead ≤ 13×10×BAUD_DIV + 40 clocks.
- Arithmetic: the BCD for 255 is 2/5/5. No value above 255 is possible because inputs are 8-bit.
- data_in changes after capture do not affect the message in flight.

Decomposition:
- Shared package dht_report_pkg holds:
  - the state enum (IDLE, CONVERT, LOAD, SEND, FINISH);
  - ASCII constants (CH_T, CH_H, CH_EQ, CH_SP, CH_CR, CH_LF, CH_E, CH_R, CH_ZERO);
  - message lengths MSG_LEN_OK=13 and MSG_LEN_ERR=5.
- One sub-module, uart_tx_byte, is natural:
  - parameter BAUD_DIV;
  - ports clk, rst_n, start, data[7:0], tx, tx_done (one-clock pulse at end of stop bit), tx_busy;
  - start is accepted only when tx_busy=0.
- The top level holds the edge detect, BCD conversion, character mux and message FSM.

Test Plan:
- Normal message: data_in=0x1928, pulse data_valid for 1 clk. Decode tx at BAUD_DIV=868 and require "T=025 H=040\r\n". done pulses once; busy is low afterwards.
- Maximum value: data_in=0xFFFF, data_valid held high for 1000 clks. Exactly one "T=255 H=255\r\n" is sent, with no retrigger while the level stays high.
- Error word: data_in=0x0000, pulse data_valid. Require "ERR\r\n", done pulses, 5 frames total.
- Busy rejection: trigger with 0x0A05; mid-message, trigger again with 0x1111. Only "T=010 H=005\r\n" is sent; after done, a new trigger with 0x1111 sends "T=017 H=017\r\n".
- Bit timing: on the first character 'T', measure the start bit and each data bit. Each must be 868 clocks ±0, with bit pattern 0,0,0,1,0,1,0,1,0 followed by stop bit 1.
- Reset mid-message: assert rst_n=0 during the 4th character. tx=1, busy=0, done=0 immediately. After release, tx stays high until a new trigger; a new trigger with 0x1928 sends the full correct line.
